// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit that sits
//   beside the execute stage. One shared (DATA_WIDTH+1)-bit adder is used for
//   both shift-add multiply and restoring shift-subtract divide, one bit per
//   cycle, on operand magnitudes; the sign is restored when the result is
//   written.
//
//   Optional build macro: MULDIV_EARLY_OUT_EN
//     defined   : divide by zero, signed overflow and zero multiply operands
//                 skip CALC and finish in the cycle after accept.
//     undefined : every op runs the full iteration count; the same special
//                 results are forced when the op completes.
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start_i     issue request, sampled only in IDLE
//   flush_i     abort the current op; wins over start_i
//   op_i        funct3 (000 MUL .. 111 REMU)
//   srcA_i      rs1 operand (multiplicand / dividend)
//   srcB_i      rs2 operand (multiplier / divisor)
//   rd_i        destination register of the issuing instruction
//   busy_o      high in CALC or DONE
//   stall_o     pipeline freeze: accept cycle and CALC
//   done_o      one-cycle pulse, result_o/rd_o valid
//   result_o    final result, held until the next completed op
//   rd_o        destination register, held with result_o
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] srcA_i,
  input  logic [DATA_WIDTH-1:0] srcB_i,
  input  logic [4:0]            rd_i,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [4:0]            rd_o
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] INT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [DW-1:0]   a_mag_q;
  logic [DW-1:0]   b_mag_q;
  logic            a_neg_q;
  logic            neg_res_q;
  logic            div_zero_q;
  logic            special_q;
  logic [CW-1:0]   cnt_q;
  // mul: {partial product, remaining multiplier bits}
  // div: {partial remainder, dividend bits shifting out / quotient shifting in}
  logic [2*DW-1:0] prod_q;

  // Special-case result; op_hi = op[2:1] (div/rem selection).
  function automatic logic [DW-1:0] special_value(input logic [1:0] op_hi,
                                                  input logic [DW-1:0] a,
                                                  input logic dz);
    if (!op_hi[1])
      return '0;
    else if (dz)
      return op_hi[0] ? a : '1;
    else
      return op_hi[0] ? '0 : INT_MIN;
  endfunction

  // ---------------- accept-cycle operand decode ----------------
  logic          acc_a_signed, acc_b_signed, acc_a_neg, acc_b_neg;
  logic          acc_neg_res, acc_div_zero, acc_ovf, acc_mul_zero, acc_special;
  logic [DW-1:0] acc_a_mag, acc_b_mag;

  always_comb begin
    if (op_i[2]) begin
      acc_a_signed = ~op_i[0];
      acc_b_signed = ~op_i[0];
    end else begin
      acc_a_signed = (op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10);
      acc_b_signed = (op_i[1:0] == 2'b01);
    end
    acc_a_neg    = acc_a_signed & srcA_i[DW-1];
    acc_b_neg    = acc_b_signed & srcB_i[DW-1];
    acc_a_mag    = acc_a_neg ? -srcA_i : srcA_i;
    acc_b_mag    = acc_b_neg ? -srcB_i : srcB_i;
    // Remainder takes the dividend's sign; quotient/product the xor.
    acc_neg_res  = (op_i[2] & op_i[1]) ? acc_a_neg : (acc_a_neg ^ acc_b_neg);
    acc_div_zero = op_i[2] & (srcB_i == '0);
    acc_ovf      = op_i[2] & ~op_i[0] & (srcA_i == INT_MIN) & (srcB_i == '1);
    acc_mul_zero = ~op_i[2] & ((srcA_i == '0) | (srcB_i == '0));
    acc_special  = acc_div_zero | acc_ovf | acc_mul_zero;
  end

  // ---------------- shared iteration datapath ----------------
  logic [DW-1:0]   prod_hi, prod_lo;
  logic [DW:0]     add_lhs, add_rhs, add_sum;
  logic [2*DW-1:0] prod_nxt;

  assign prod_hi = prod_q[2*DW-1:DW];
  assign prod_lo = prod_q[DW-1:0];

  always_comb begin
    add_lhs  = op_q[2] ? {prod_hi, prod_lo[DW-1]} : {1'b0, prod_hi};
    // Divide subtracts via invert + carry-in on the same adder.
    add_rhs  = op_q[2] ? ~{1'b0, b_mag_q} : (prod_lo[0] ? {1'b0, a_mag_q} : '0);
    add_sum  = add_lhs + add_rhs + {{DW{1'b0}}, op_q[2]};
    prod_nxt = '0;
    if (op_q[2]) begin
      // add_sum[DW] set means borrow: restore the shifted remainder.
      if (add_sum[DW])
        prod_nxt = {add_lhs[DW-1:0], prod_lo[DW-2:0], 1'b0};
      else
        prod_nxt = {add_sum[DW-1:0], prod_lo[DW-2:0], 1'b1};
    end else begin
      prod_nxt = {add_sum, prod_lo[DW-1:1]};
    end
  end

  // ---------------- result finalisation (last iteration) ----------------
  logic [2*DW-1:0] full_prod;
  logic [DW-1:0]   div_val, a_orig, fin_result;

  always_comb begin
    a_orig    = a_neg_q ? -a_mag_q : a_mag_q;
    full_prod = neg_res_q ? -prod_nxt : prod_nxt;
    div_val   = op_q[1] ? prod_nxt[2*DW-1:DW] : prod_nxt[DW-1:0];
    if (special_q)
      fin_result = special_value(op_q[2:1], a_orig, div_zero_q);
    else if (op_q[2])
      fin_result = neg_res_q ? -div_val : div_val;
    else if (op_q[1:0] == 2'b00)
      fin_result = full_prod[DW-1:0];
    else
      fin_result = full_prod[2*DW-1:DW];
  end

  // ---------------- control ----------------
  assign busy_o  = (state_q != ST_IDLE);
  assign stall_o = ((state_q == ST_IDLE) & start_i & ~flush_i) | (state_q == ST_CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      a_neg_q    <= 1'b0;
      neg_res_q  <= 1'b0;
      div_zero_q <= 1'b0;
      special_q  <= 1'b0;
      cnt_q      <= '0;
      prod_q     <= '0;
      done_o     <= 1'b0;
      result_o   <= '0;
      rd_o       <= '0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      done_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            op_q       <= op_i;
            rd_q       <= rd_i;
            a_mag_q    <= acc_a_mag;
            b_mag_q    <= acc_b_mag;
            a_neg_q    <= acc_a_neg;
            neg_res_q  <= acc_neg_res;
            div_zero_q <= acc_div_zero;
            special_q  <= acc_special;
            cnt_q      <= '0;
            prod_q     <= {{DW{1'b0}}, (op_i[2] ? acc_a_mag : acc_b_mag)};
`ifdef MULDIV_EARLY_OUT_EN
            if (acc_special) begin
              state_q  <= ST_DONE;
              done_o   <= 1'b1;
              result_o <= special_value(op_i[2:1], srcA_i, acc_div_zero);
              rd_o     <= rd_i;
            end else begin
              state_q <= ST_CALC;
            end
`else
            state_q <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          prod_q <= prod_nxt;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            state_q  <= ST_DONE;
            done_o   <= 1'b1;
            result_o <= fin_result;
            rd_o     <= rd_q;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_o  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int LAT_FULL = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_SPEC = 1;
`else
  localparam int LAT_SPEC = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  op_i;
  logic [31:0] srcA_i;
  logic [31:0] srcB_i;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .op_i     (op_i),
    .srcA_i   (srcA_i),
    .srcB_i   (srcB_i),
    .rd_i     (rd_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op and hold start_i until done_o. With disturb set, the
  // operand/op/rd inputs are changed mid-CALC while start_i stays high.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input bit disturb);
    int lat    = 0;
    int stalls = 0;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    srcA_i  = a;
    srcB_i  = b;
    rd_i    = rd;
    #1;
    check({tag, "_stall_acc"}, {31'b0, stall_o}, 32'd1);
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (done_o) begin
        lat     = k;
        start_i = 1'b0;
      end
      if (disturb && k == 5) begin
        op_i   = 3'b000;
        srcA_i = 32'h1234_5678;
        srcB_i = 32'h0000_0003;
        rd_i   = 5'd31;
      end
    end
    start_i = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_stalls"}, stalls, exp_lat - 1);
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_rd"}, {27'b0, rd_o}, {27'b0, rd});
    @(negedge clk);
    check({tag, "_pulse"}, {30'b0, done_o, busy_o}, 32'd0);
  endtask

  initial begin
    int dones;
    rst_n   = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    srcA_i  = '0;
    srcB_i  = '0;
    rd_i    = '0;
    #1;
    check("rst_ctrl", {29'b0, busy_o, stall_o, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", {27'b0, rd_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply family
    run_op("mul",     3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT_FULL, 1'b0);
    run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, LAT_FULL, 1'b0);
    run_op("mulh",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, LAT_FULL, 1'b0);
    run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, LAT_FULL, 1'b0);
    run_op("mulhu2",  3'b011, 32'h8000_0000, 32'h0000_0004, 5'd9,  32'h0000_0002, LAT_FULL, 1'b0);
    run_op("mulzero", 3'b000, 32'h0000_0000, 32'h1234_5678, 5'd10, 32'h0000_0000, LAT_SPEC, 1'b0);

    // Divide family
    run_op("div",     3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFD, LAT_FULL, 1'b0);
    run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFF, LAT_FULL, 1'b0);
    run_op("divu",    3'b101, 32'd100,       32'd7,         5'd13, 32'd14,        LAT_FULL, 1'b0);
    run_op("remu",    3'b111, 32'd100,       32'd7,         5'd14, 32'd2,         LAT_FULL, 1'b0);
    run_op("div_nd",  3'b100, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, LAT_FULL, 1'b0);
    run_op("rem_nd",  3'b110, 32'd7,         32'hFFFF_FFFE, 5'd16, 32'd1,         LAT_FULL, 1'b0);
    run_op("divu_bg", 3'b101, 32'hFFFF_FFFF, 32'd1,         5'd17, 32'hFFFF_FFFF, LAT_FULL, 1'b0);

    // Special cases
    run_op("div0",    3'b100, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, LAT_SPEC, 1'b0);
    run_op("rem0",    3'b110, 32'd5,         32'd0,         5'd19, 32'd5,         LAT_SPEC, 1'b0);
    run_op("divn0",   3'b100, 32'hFFFF_FFF9, 32'd0,         5'd20, 32'hFFFF_FFFF, LAT_SPEC, 1'b0);
    run_op("remn0",   3'b110, 32'hFFFF_FFF9, 32'd0,         5'd21, 32'hFFFF_FFF9, LAT_SPEC, 1'b0);
    run_op("divovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, LAT_SPEC, 1'b0);
    run_op("removf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0000_0000, LAT_SPEC, 1'b0);

    // Inputs changing mid-CALC with start_i held must not affect the op
    run_op("restart", 3'b101, 32'd100,       32'd7,         5'd3,  32'd14,        LAT_FULL, 1'b1);

    // Flush at iteration 10: back to IDLE, no done_o, outputs unchanged
    @(negedge clk);
    start_i = 1'b1;
    op_i    = 3'b000;
    srcA_i  = 32'd9;
    srcB_i  = 32'd9;
    rd_i    = 5'd25;
    dones   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy", {31'b0, busy_o}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    check("flush_nodone", dones, 32'd0);
    check("flush_result", result_o, 32'd14);
    check("flush_rd", {27'b0, rd_o}, 32'd3);

    // start_i and flush_i together: not accepted
    @(negedge clk);
    start_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("sf_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    check("sf_busy", {31'b0, busy_o}, 32'd0);
    start_i = 1'b0;
    flush_i = 1'b0;

    // Reset during CALC: outputs clear immediately
    @(negedge clk);
    start_i = 1'b1;
    op_i    = 3'b011;
    srcA_i  = 32'd1000;
    srcB_i  = 32'd1000;
    rd_i    = 5'd26;
    for (int k = 0; k < 6; k++) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy_o}, 32'd1);
    start_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_ctrl", {29'b0, busy_o, stall_o, done_o}, 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    check("mid_rst_rd", {27'b0, rd_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 3'b111, 32'd100, 32'd7, 5'd27, 32'd2, LAT_FULL, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
